// File: rtl/pdp1_shrot_exec_if.sv
// Bus between the shift-group controller and the sequential shift/rotate executor.
// Handshake: sh_start is sampled only while sh_busy=0; sh_busy rises the cycle after an
// accepted start and falls after the single-cycle sh_done pulse; results are valid with sh_done.
interface pdp1_shrot_exec_if;
    logic        sh_start;
    logic        sh_dir;
    logic        sh_rot;
    logic [1:0]  sh_sel;
    logic [0:3]  sh_cnt;
    logic [0:17] ac_in;
    logic [0:17] io_in;
    logic [0:17] ac_out;
    logic [0:17] io_out;
    logic        sh_busy;
    logic        sh_done;

    modport master (
        output sh_start, sh_dir, sh_rot, sh_sel, sh_cnt, ac_in, io_in,
        input  ac_out, io_out, sh_busy, sh_done
    );

    modport slave (
        input  sh_start, sh_dir, sh_rot, sh_sel, sh_cnt, ac_in, io_in,
        output ac_out, io_out, sh_busy, sh_done
    );
endinterface

// File: rtl/pdp1_shrot_exec.sv
// PDP-1 shift group executor: moves AC, IO or AC:IO one bit per clock for a clamped count.
// Bit 0 is the sign bit; arithmetic shifts keep it and refill bit 17 (left) or bit 1 (right).
module pdp1_shrot_exec (
    input  logic              clk,
    input  logic              rst_n,
    pdp1_shrot_exec_if.slave  bus,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  rem_q;
    logic        dir_q;
    logic        rot_q;
    logic [1:0]  sel_q;
    logic [0:17] ac_q;
    logic [0:17] io_q;
    logic [0:17] ac_d;
    logic [0:17] io_d;
    logic        busy_q;
    logic        done_q;
    logic [3:0]  cnt_clamp;

    assign cnt_clamp = (bus.sh_cnt > 4'd9) ? 4'd9 : bus.sh_cnt;

    function automatic logic [0:17] step18(input logic [0:17] v, input logic dir,
                                           input logic rot);
        logic [0:17] r;
        if (rot) r = dir ? {v[17], v[0:16]} : {v[1:17], v[0]};
        else     r = dir ? {v[0], v[0], v[1:16]} : {v[0], v[2:17], v[0]};
        return r;
    endfunction

    // One step of the latched operation; sel=00 leaves both registers untouched.
    always_comb begin
        ac_d = ac_q;
        io_d = io_q;
        case (sel_q)
            2'b01: ac_d = step18(ac_q, dir_q, rot_q);
            2'b10: io_d = step18(io_q, dir_q, rot_q);
            2'b11: begin
                if (rot_q && !dir_q) begin
                    ac_d = {ac_q[1:17], io_q[0]};
                    io_d = {io_q[1:17], ac_q[0]};
                end else if (rot_q && dir_q) begin
                    ac_d = {io_q[17], ac_q[0:16]};
                    io_d = {ac_q[17], io_q[0:16]};
                end else if (!dir_q) begin
                    ac_d = {ac_q[0], ac_q[2:17], io_q[0]};
                    io_d = {io_q[1:17], ac_q[0]};
                end else begin
                    ac_d = {ac_q[0], ac_q[0], ac_q[1:16]};
                    io_d = {ac_q[17], io_q[0:16]};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= 4'd0;
            dir_q   <= 1'b0;
            rot_q   <= 1'b0;
            sel_q   <= 2'b00;
            ac_q    <= 18'd0;
            io_q    <= 18'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.sh_start) begin
                        ac_q   <= bus.ac_in;
                        io_q   <= bus.io_in;
                        dir_q  <= bus.sh_dir;
                        rot_q  <= bus.sh_rot;
                        sel_q  <= bus.sh_sel;
                        rem_q  <= cnt_clamp;
                        busy_q <= 1'b1;
                        if (cnt_clamp == 4'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    ac_q  <= ac_d;
                    io_q  <= io_d;
                    rem_q <= rem_q - 4'd1;
                    if (rem_q == 4'd1) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ac_out  = ac_q;
    assign bus.io_out  = io_q;
    assign bus.sh_busy = busy_q;
    assign bus.sh_done = done_q;
    assign dbg_state_o = state_q;

endmodule
